mem_byte_sequencer: RTL and testbench



---
 rtl/mem_byte_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mem_byte_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_sequencer.sv
// Byte-serial load/store sequencer for a 64x8 big-endian data memory; MSB byte first.
// Latency accept->resp_valid: store N+1, load N+2, rejected access 1 cycle.
// req_ready is low while busy; no response backpressure. MEM_SEQ_UNALIGNED_EN drops the alignment check.
module mem_byte_sequencer #(
    parameter int ADDR_W    = 6,
    parameter int MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

    localparam logic [ADDR_W+1:0] MEM_LIM = (ADDR_W+2)'(MEM_BYTES);

    state_t      state, state_nxt;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic [31:0] acc;
    logic [1:0]  idx;
    logic [1:0]  last_q;

    logic [2:0]        n_req;
    logic [1:0]        last_req;
    logic              misalign;
    logic              oob;
    logic              req_err;
    logic [ADDR_W+1:0] end_addr;
    logic [1:0]        sel;
    logic              accept;
    logic              access_done;
    logic [31:0]       acc_nxt;

    always_comb begin
        n_req    = 3'd1;
        last_req = 2'd0;
        case (req_size)
            2'b01:   begin n_req = 3'd2; last_req = 2'd1; end
            2'b10:   begin n_req = 3'd4; last_req = 2'd3; end
            default: begin n_req = 3'd1; last_req = 2'd0; end
        endcase
    end

`ifdef MEM_SEQ_UNALIGNED_EN
    assign misalign = 1'b0;
`else
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`endif

    // Two extra bits keep addr+N-1 from wrapping back into range.
    assign end_addr = {2'b00, req_addr} + {{(ADDR_W-1){1'b0}}, n_req} - (ADDR_W+2)'(1);
    assign oob      = (end_addr >= MEM_LIM);
    assign req_err  = (req_size == 2'b11) || misalign || oob;

    assign accept      = (state == IDLE) && req_valid;
    assign access_done = (state == ACCESS) && (idx == last_q);
    assign acc_nxt     = {acc[23:0], mem_rdata};

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size,
                                           input logic uns);
        logic [31:0] r;
        case (size)
            2'b00:   r = {{24{~uns & v[7]}}, v[7:0]};
            2'b01:   r = {{16{~uns & v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = 8'h00;
        sel        = last_q - idx;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_we = we_q;
                if (we_q) begin
                    mem_wdata = wdata_q[{sel, 3'b000} +: 8];
                end
                if (idx == last_q) begin
                    state_nxt = we_q ? RESP : DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            wdata_q    <= 32'h0;
            acc        <= 32'h0;
            idx        <= 2'd0;
            last_q     <= 2'd0;
            mem_addr   <= '0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                wdata_q <= req_wdata;
                acc     <= 32'h0;
                idx     <= 2'd0;
                last_q  <= last_req;
                if (req_err) begin
                    resp_err   <= 1'b1;
                    resp_rdata <= 32'h0;
                end else begin
                    mem_addr <= req_addr;
                end
            end
            if (state == ACCESS) begin
                if (idx != last_q) begin
                    idx      <= idx + 2'd1;
                    mem_addr <= mem_addr + ADDR_W'(1);
                end
                // Read data trails the address by one cycle, so byte 0 lands on the second access cycle.
                if (!we_q && (idx != 2'd0)) begin
                    acc <= acc_nxt;
                end
                if (access_done && we_q) begin
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
            end
            if (state == DRAIN) begin
                acc        <= acc_nxt;
                resp_err   <= 1'b0;
                resp_rdata <= extend(acc_nxt, size_q, uns_q);
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer with a synchronous-read 64x8 memory model.
module tb_mem_byte_sequencer;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    logic [7:0]        mem [0:63];
    logic [ADDR_W-1:0] wa [$];
    logic [7:0]        wd [$];
    int                wc [$];
    int                cyc = 0;

    int checks = 0;
    int failures = 0;

    mem_byte_sequencer #(.ADDR_W(ADDR_W), .MEM_BYTES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [5:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err);
        bit got;
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; got = 1'b0; rdata = 32'h0; err = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                got = 1'b1;
                rdata = resp_rdata;
                err = resp_err;
            end
        end
        if (!got) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          base;
        int          wcount;
        logic [7:0]  exp_b [4];

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", {26'b0, mem_addr}, 32'd0);
        chk("rst_wdata", {24'b0, mem_wdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store: four consecutive MSB-first byte writes.
        base = wa.size();
        do_req(1'b1, 2'b10, 1'b0, 6'd8, 32'h11223344, lat, rd, er);
        chk("stw_lat", lat, 32'd5);
        chk("stw_err", {31'b0, er}, 32'd0);
        chk("stw_rdata", rd, 32'h0);
        chk("stw_cnt", wa.size() - base, 32'd4);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            chk("stw_addr", {26'b0, wa[base+i]}, 8 + i);
            chk("stw_data", {24'b0, wd[base+i]}, {24'b0, exp_b[i]});
        end
        chk("stw_consec", wc[base+3] - wc[base], 32'd3);

        do_req(1'b0, 2'b10, 1'b0, 6'd8, 32'h0, lat, rd, er);
        chk("ldw_lat", lat, 32'd6);
        chk("ldw_data", rd, 32'h11223344);
        chk("ldw_err", {31'b0, er}, 32'd0);
        @(negedge clk);
        chk("hold_valid", {31'b0, resp_valid}, 32'd0);
        chk("hold_rdata", resp_rdata, 32'h11223344);

        do_req(1'b1, 2'b00, 1'b0, 6'd3, 32'h00000080, lat, rd, er);
        chk("stb_lat", lat, 32'd2);
        chk("stb_mem", {24'b0, mem[3]}, 32'h80);
        do_req(1'b0, 2'b00, 1'b0, 6'd3, 32'h0, lat, rd, er);
        chk("ldb_s_lat", lat, 32'd3);
        chk("ldb_s_data", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b1, 6'd3, 32'h0, lat, rd, er);
        chk("ldb_u_data", rd, 32'h00000080);

        do_req(1'b1, 2'b01, 1'b0, 6'd4, 32'h00008001, lat, rd, er);
        chk("sth_lat", lat, 32'd3);
        do_req(1'b0, 2'b01, 1'b0, 6'd4, 32'h0, lat, rd, er);
        chk("ldh_s_lat", lat, 32'd4);
        chk("ldh_s_data", rd, 32'hFFFF8001);
        do_req(1'b0, 2'b01, 1'b1, 6'd4, 32'h0, lat, rd, er);
        chk("ldh_u_data", rd, 32'h00008001);

        do_req(1'b1, 2'b01, 1'b0, 6'd6, 32'h0000BEEF, lat, rd, er);
        chk("sth6_err", {31'b0, er}, 32'd0);

        wcount = wa.size();
`ifdef MEM_SEQ_UNALIGNED_EN
        do_req(1'b0, 2'b10, 1'b0, 6'd6, 32'h0, lat, rd, er);
        chk("ldw6_err", {31'b0, er}, 32'd0);
        chk("ldw6_lat", lat, 32'd6);
        chk("ldw6_data", rd, 32'hBEEF1122);
        do_req(1'b1, 2'b10, 1'b0, 6'd6, 32'h12345678, lat, rd, er);
        chk("stw6_err", {31'b0, er}, 32'd0);
        chk("stw6_mem9", {24'b0, mem[9]}, 32'h78);
        wcount = wa.size();
`else
        do_req(1'b0, 2'b10, 1'b0, 6'd6, 32'h0, lat, rd, er);
        chk("ldw6_err", {31'b0, er}, 32'd1);
        chk("ldw6_lat", lat, 32'd1);
        chk("ldw6_data", rd, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 6'd5, 32'h0000FFFF, lat, rd, er);
        chk("sth5_err", {31'b0, er}, 32'd1);
        chk("sth5_lat", lat, 32'd1);
        chk("sth5_nowr", wa.size() - wcount, 32'd0);
`endif

        do_req(1'b1, 2'b10, 1'b0, 6'd60, 32'hCAFEF00D, lat, rd, er);
        chk("stw60_err", {31'b0, er}, 32'd0);
        chk("stw60_lat", lat, 32'd5);
        do_req(1'b0, 2'b10, 1'b0, 6'd60, 32'h0, lat, rd, er);
        chk("ldw60_data", rd, 32'hCAFEF00D);

        wcount = wa.size();
        do_req(1'b0, 2'b10, 1'b0, 6'd61, 32'h0, lat, rd, er);
        chk("ldw61_err", {31'b0, er}, 32'd1);
        chk("ldw61_lat", lat, 32'd1);
        do_req(1'b1, 2'b10, 1'b0, 6'd62, 32'h0, lat, rd, er);
        chk("stw62_err", {31'b0, er}, 32'd1);
        chk("stw62_nowr", wa.size() - wcount, 32'd0);
        do_req(1'b0, 2'b11, 1'b0, 6'd0, 32'h0, lat, rd, er);
        chk("size11_err", {31'b0, er}, 32'd1);
        chk("size11_rdata", rd, 32'h0);

        // Abort a word store after its first two bytes have been written.
        do_req(1'b1, 2'b10, 1'b0, 6'd20, 32'h55667788, lat, rd, er);
        do_req(1'b0, 2'b11, 1'b0, 6'd0, 32'h0, lat, rd, er);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_addr = 6'd20; req_wdata = 32'hAABBCCDD;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_we", {31'b0, mem_we}, 32'd0);
        chk("abort_addr", {26'b0, mem_addr}, 32'd0);
        chk("abort_err", {31'b0, resp_err}, 32'd0);
        chk("abort_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_m20", {24'b0, mem[20]}, 32'hAA);
        chk("abort_m21", {24'b0, mem[21]}, 32'hBB);
        chk("abort_m22", {24'b0, mem[22]}, 32'h77);
        chk("abort_m23", {24'b0, mem[23]}, 32'h88);
        do_req(1'b0, 2'b10, 1'b0, 6'd20, 32'h0, lat, rd, er);
        chk("post_rst_lat", lat, 32'd6);
        chk("post_rst_data", rd, 32'hAABB7788);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
